// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the conv_mac_layer convolution block.
// Holds the FSM state type, the accumulator sizing helper and the
// shift / ReLU / saturate helper applied to every finished accumulator.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    // Accumulator width that can hold K*K*IN_CH full-scale products without overflow.
    function automatic int acc_bits(input int data_bits, input int w_bits,
                                    input int k, input int in_ch);
        return data_bits + w_bits + $clog2(k * k * in_ch);
    endfunction

    // Arithmetic right shift, optional clamp of negatives to zero, then
    // saturation to the signed data_bits range. Works on a 64-bit value so it
    // serves any accumulator width; the caller keeps the low data_bits bits.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                     input int shift,
                                                     input int data_bits,
                                                     input logic relu);
        logic signed [63:0] v;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        v     = acc >>> shift;
        if (relu && (v < 64'sd0)) begin
            v = '0;
        end
        max_v = (64'sd1 <<< (data_bits - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (data_bits - 1));
        if (v > max_v) begin
            v = max_v;
        end else if (v < min_v) begin
            v = min_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/line_window_buf.sv
// line_window_buf: per-channel line/window shift buffer.
// Holds the last (K-1)*WIDTH+K samples of a raster stream so that the full
// KxK window ending at the most recent sample can be read one tap at a time.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (clears storage)
//   en              shift in din (only on an accepted pixel)
//   din             new sample
//   tap_y, tap_x    window row/column to read (0,0 = oldest corner)
//   dout            sample at window position (tap_y, tap_x)
module line_window_buf #(
    parameter int WIDTH     = 12,
    parameter int K         = 5,
    parameter int DATA_BITS = 12,
    localparam int TAP_BITS = (K > 1) ? $clog2(K) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [DATA_BITS-1:0]        din,
    input  logic [TAP_BITS-1:0]         tap_y,
    input  logic [TAP_BITS-1:0]         tap_x,
    output logic signed [DATA_BITS-1:0] dout
);

    localparam int LEN = (K - 1) * WIDTH + K;
    localparam int AW  = $clog2(LEN);

    logic signed [DATA_BITS-1:0] taps [LEN];
    logic [AW-1:0]               age;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LEN; i++) begin
                taps[i] <= '0;
            end
        end else if (en) begin
            taps[0] <= $signed(din);
            for (int i = 1; i < LEN; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    // taps[0] is the window's bottom-right sample; each row up is WIDTH older
    // and each column left is one older.
    always_comb begin
        age = AW'((K - 1 - int'(tap_y)) * WIDTH + (K - 1 - int'(tap_x)));
    end

    assign dout = taps[age];

endmodule

// File: rtl/conv_mac_layer.sv
// conv_mac_layer: multi-channel valid 2-D convolution (stride 1) over a raster
// pixel stream, with runtime-loadable weights and one time-multiplexed MAC
// array that walks the K*K taps of each window while stalling the input.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   valid_in/in_ready       input pixel handshake
//   data_in                 IN_CH packed samples
//   w_we/w_addr/w_data      weight write port (honoured only while idle)
//   valid_out_conv          one-cycle pulse, conv_out valid
//   conv_out                OUT_CH packed results
//   frame_done              pulses with the last output of a frame
module conv_mac_layer
    import conv_pkg::*;
#(
    parameter int IN_CH     = 3,
    parameter int OUT_CH    = 3,
    parameter int WIDTH     = 12,
    parameter int HEIGHT    = 12,
    parameter int K         = 5,
    parameter int DATA_BITS = 12,
    parameter int W_BITS    = 8,
    parameter int SHIFT     = 1,
    parameter int RELU_EN   = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    valid_in,
    output logic                                    in_ready,
    input  logic [IN_CH*DATA_BITS-1:0]              data_in,
    input  logic                                    w_we,
    input  logic [$clog2(OUT_CH*IN_CH*K*K)-1:0]     w_addr,
    input  logic [W_BITS-1:0]                       w_data,
    output logic                                    valid_out_conv,
    output logic [OUT_CH*DATA_BITS-1:0]             conv_out,
    output logic                                    frame_done
);

    localparam int ACC_BITS  = acc_bits(DATA_BITS, W_BITS, K, IN_CH);
    localparam int PROD_BITS = DATA_BITS + W_BITS;
    localparam int NUM_W     = OUT_CH * IN_CH * K * K;
    localparam int WA_BITS   = $clog2(NUM_W);
    localparam int TAP_BITS  = (K > 1) ? $clog2(K) : 1;
    localparam int COL_BITS  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_BITS  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    state_t                      state;
    logic [TAP_BITS-1:0]         ky;
    logic [TAP_BITS-1:0]         kx;
    logic [COL_BITS-1:0]         col;
    logic [ROW_BITS-1:0]         row;
    logic                        last_win;
    logic signed [ACC_BITS-1:0]  acc      [OUT_CH];
    logic signed [ACC_BITS-1:0]  acc_next [OUT_CH];
    logic signed [DATA_BITS-1:0] result   [OUT_CH];
    logic signed [DATA_BITS-1:0] win      [IN_CH];
    logic signed [W_BITS-1:0]    weights  [NUM_W];
    logic                        accept;
    logic                        win_done;
    logic                        frame_end;
    logic                        last_tap;

    assign accept    = valid_in && in_ready;
    assign win_done  = (row >= ROW_BITS'(K - 1)) && (col >= COL_BITS'(K - 1));
    assign frame_end = (row == ROW_BITS'(HEIGHT - 1)) && (col == COL_BITS'(WIDTH - 1));
    assign last_tap  = (ky == TAP_BITS'(K - 1)) && (kx == TAP_BITS'(K - 1));

    // The buffers only shift on accepted pixels, so the window is frozen while
    // in_ready is low and the taps can be read across the MAC phase.
    for (genvar ic = 0; ic < IN_CH; ic++) begin : g_buf
        line_window_buf #(
            .WIDTH    (WIDTH),
            .K        (K),
            .DATA_BITS(DATA_BITS)
        ) u_buf (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (accept),
            .din  (data_in[ic*DATA_BITS +: DATA_BITS]),
            .tap_y(ky),
            .tap_x(kx),
            .dout (win[ic])
        );
    end

    // Weights survive reset and may only change between windows.
    always_ff @(posedge clk) begin
        if (w_we && (state == IDLE) && (int'(w_addr) < NUM_W)) begin
            weights[w_addr] <= $signed(w_data);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_BITS'(WIDTH - 1)) begin
                col <= '0;
                row <= (row == ROW_BITS'(HEIGHT - 1)) ? '0 : row + ROW_BITS'(1);
            end else begin
                col <= col + COL_BITS'(1);
            end
        end
    end

    // One tap per cycle: every output channel adds the products of all input
    // channels at the current (ky,kx). The post-processed result is derived
    // from acc_next so the final tap can be registered straight into conv_out.
    always_comb begin
        for (int oc = 0; oc < OUT_CH; oc++) begin
            acc_next[oc] = acc[oc];
            for (int ic = 0; ic < IN_CH; ic++) begin
                logic signed [PROD_BITS-1:0] prod;
                int                          widx;
                widx = ((oc * IN_CH + ic) * K + int'(ky)) * K + int'(kx);
                prod = PROD_BITS'(win[ic]) * PROD_BITS'(weights[WA_BITS'(widx)]);
                acc_next[oc] = acc_next[oc] + ACC_BITS'(prod);
            end
            result[oc] = DATA_BITS'(sat_shift(64'(acc_next[oc]), SHIFT, DATA_BITS,
                                              RELU_EN != 0));
        end
    end

    // Control FSM. The result is latched on the last MAC tap so that
    // valid_out_conv and conv_out are both visible during the OUT cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            ky             <= '0;
            kx             <= '0;
            last_win       <= 1'b0;
            valid_out_conv <= 1'b0;
            frame_done     <= 1'b0;
            conv_out       <= '0;
            for (int oc = 0; oc < OUT_CH; oc++) begin
                acc[oc] <= '0;
            end
        end else begin
            valid_out_conv <= 1'b0;
            frame_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && win_done) begin
                        state    <= MAC;
                        in_ready <= 1'b0;
                        ky       <= '0;
                        kx       <= '0;
                        last_win <= frame_end;
                        for (int oc = 0; oc < OUT_CH; oc++) begin
                            acc[oc] <= '0;
                        end
                    end
                end
                MAC: begin
                    for (int oc = 0; oc < OUT_CH; oc++) begin
                        acc[oc] <= acc_next[oc];
                    end
                    if (last_tap) begin
                        state          <= OUT;
                        valid_out_conv <= 1'b1;
                        frame_done     <= last_win;
                        for (int oc = 0; oc < OUT_CH; oc++) begin
                            conv_out[oc*DATA_BITS +: DATA_BITS] <= result[oc];
                        end
                    end else if (kx == TAP_BITS'(K - 1)) begin
                        kx <= '0;
                        ky <= ky + TAP_BITS'(1);
                    end else begin
                        kx <= kx + TAP_BITS'(1);
                    end
                end
                OUT: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_layer.sv
// tb_conv_mac_layer: directed and randomized frames for conv_mac_layer.
// Two instances share all inputs: one plain (SHIFT=0, no ReLU) and one with
// SHIFT=1 and ReLU enabled. Expected outputs come from a direct window-sum
// model over the frame's pixel and weight arrays.
module tb_conv_mac_layer;

    localparam int IN_CH    = 2;
    localparam int OUT_CH   = 2;
    localparam int WIDTH    = 6;
    localparam int HEIGHT   = 6;
    localparam int K        = 3;
    localparam int DB       = 12;
    localparam int WB       = 8;
    localparam int NUM_W    = OUT_CH * IN_CH * K * K;
    localparam int WA       = $clog2(NUM_W);
    localparam int NUM_OUT  = (WIDTH - K + 1) * (HEIGHT - K + 1);
    localparam int NUM_PIX  = WIDTH * HEIGHT;
    localparam int STALL    = K * K + 1;
    localparam int WIN_PIX  = (K - 1) * WIDTH + (K - 1);

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   valid_in = 1'b0;
    logic [IN_CH*DB-1:0]    data_in = '0;
    logic                   w_we = 1'b0;
    logic [WA-1:0]          w_addr = '0;
    logic [WB-1:0]          w_data = '0;
    logic                   in_ready, valid_out_conv, frame_done;
    logic [OUT_CH*DB-1:0]   conv_out;
    logic                   in_ready_r, valid_r, frame_done_r;
    logic [OUT_CH*DB-1:0]   conv_out_r;

    conv_mac_layer #(
        .IN_CH(IN_CH), .OUT_CH(OUT_CH), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .K(K),
        .DATA_BITS(DB), .W_BITS(WB), .SHIFT(0), .RELU_EN(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .in_ready(in_ready),
        .data_in(data_in), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .valid_out_conv(valid_out_conv), .conv_out(conv_out), .frame_done(frame_done)
    );

    conv_mac_layer #(
        .IN_CH(IN_CH), .OUT_CH(OUT_CH), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .K(K),
        .DATA_BITS(DB), .W_BITS(WB), .SHIFT(1), .RELU_EN(1)
    ) dut_relu (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .in_ready(in_ready_r),
        .data_in(data_in), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .valid_out_conv(valid_r), .conv_out(conv_out_r), .frame_done(frame_done_r)
    );

    always #5 clk = ~clk;

    int pix [IN_CH][HEIGHT][WIDTH];
    int wt  [OUT_CH][IN_CH][K][K];
    int checks = 0;
    int failures = 0;

    int gotM0[$], gotM1[$], gotR0[$], gotR1[$];
    bit gotFd[$], gotFdR[$];
    int lowRuns[$];
    int lowRun = 0;
    int acceptCount = 0;
    int fdPulses = 0;
    int fdPulsesR = 0;

    // Output / handshake monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid_out_conv === 1'b1) begin
                gotM0.push_back(int'($signed(conv_out[0 +: DB])));
                gotM1.push_back(int'($signed(conv_out[DB +: DB])));
                gotFd.push_back(frame_done);
            end
            if (valid_r === 1'b1) begin
                gotR0.push_back(int'($signed(conv_out_r[0 +: DB])));
                gotR1.push_back(int'($signed(conv_out_r[DB +: DB])));
                gotFdR.push_back(frame_done_r);
            end
            if (frame_done === 1'b1) fdPulses++;
            if (frame_done_r === 1'b1) fdPulsesR++;
            if (valid_in && in_ready) acceptCount++;
            if (in_ready === 1'b0) begin
                lowRun++;
            end else if (lowRun > 0) begin
                lowRuns.push_back(lowRun);
                lowRun = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Floor division by 2^shift, optional ReLU, saturation to DB bits.
    function automatic int modelResult(input longint sum, input int shift, input bit relu);
        longint d, q;
        d = longint'(1) << shift;
        if (sum >= 0) q = sum / d;
        else          q = -((-sum + d - 1) / d);
        if (relu && q < 0) q = 0;
        if (q > 2047)  q = 2047;
        if (q < -2048) q = -2048;
        return int'(q);
    endfunction

    function automatic longint windowSum(input int oc, input int r0, input int c0);
        longint s = 0;
        for (int ic = 0; ic < IN_CH; ic++)
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++)
                    s += longint'(pix[ic][r0+ky][c0+kx]) * longint'(wt[oc][ic][ky][kx]);
        return s;
    endfunction

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic writeWeight(input int oc, input int ic, input int ky, input int kx, input int val);
        w_addr = WA'(((oc * IN_CH + ic) * K + ky) * K + kx);
        w_data = WB'(val);
        w_we   = 1'b1;
        @(posedge clk);
        #1 w_we = 1'b0;
    endtask

    task automatic loadWeights();
        for (int oc = 0; oc < OUT_CH; oc++)
            for (int ic = 0; ic < IN_CH; ic++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        writeWeight(oc, ic, ky, kx, wt[oc][ic][ky][kx]);
    endtask

    task automatic setWeights(input int val);
        for (int oc = 0; oc < OUT_CH; oc++)
            for (int ic = 0; ic < IN_CH; ic++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        wt[oc][ic][ky][kx] = val;
    endtask

    task automatic randomWeights(input int wmax);
        for (int oc = 0; oc < OUT_CH; oc++)
            for (int ic = 0; ic < IN_CH; ic++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        wt[oc][ic][ky][kx] = int'($urandom_range(2 * wmax)) - wmax;
    endtask

    task automatic setPixels(input int val);
        for (int ic = 0; ic < IN_CH; ic++)
            for (int r = 0; r < HEIGHT; r++)
                for (int c = 0; c < WIDTH; c++)
                    pix[ic][r][c] = val;
    endtask

    task automatic randomPixels(input int pmax);
        for (int ic = 0; ic < IN_CH; ic++)
            for (int r = 0; r < HEIGHT; r++)
                for (int c = 0; c < WIDTH; c++)
                    pix[ic][r][c] = int'($urandom_range(2 * pmax)) - pmax;
    endtask

    // Holds valid_in high until the pixel is taken (bounded wait).
    task automatic sendPixel(input int idx);
        int cyc = 0;
        for (int ic = 0; ic < IN_CH; ic++)
            data_in[ic*DB +: DB] = DB'(pix[ic][idx / WIDTH][idx % WIDTH]);
        valid_in = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        checkOutput($sformatf("accept_px%0d", idx), longint'(in_ready === 1'b1), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int first, input int last);
        for (int i = first; i <= last; i++) sendPixel(i);
        valid_in = 1'b0;
    endtask

    // Streams one frame (optionally writing weight 0 during the first MAC
    // phase), drains it, and compares everything against the model.
    task automatic runFrame(input string name, input bit midWrite, output int baseOut);
        int baseR, baseRun, baseAcc, baseFd, baseFdR, w;
        baseOut = gotM0.size();
        baseR   = gotR0.size();
        baseRun = lowRuns.size();
        baseAcc = acceptCount;
        baseFd  = fdPulses;
        baseFdR = fdPulsesR;
        if (midWrite) begin
            applyStimulus(0, WIN_PIX);
            w_addr = '0;
            w_data = WB'(5);
            w_we   = 1'b1;
            repeat (2) @(posedge clk);
            #1 w_we = 1'b0;
            applyStimulus(WIN_PIX + 1, NUM_PIX - 1);
        end else begin
            applyStimulus(0, NUM_PIX - 1);
        end
        repeat (30) @(posedge clk);
        #1;
        checkOutput({name, ".out_count"}, gotM0.size() - baseOut, NUM_OUT);
        checkOutput({name, ".out_count_relu"}, gotR0.size() - baseR, NUM_OUT);
        checkOutput({name, ".accepts"}, acceptCount - baseAcc, NUM_PIX);
        checkOutput({name, ".stalls"}, lowRuns.size() - baseRun, NUM_OUT);
        for (int j = baseRun; j < lowRuns.size(); j++)
            checkOutput($sformatf("%s.stall_len[%0d]", name, j - baseRun), lowRuns[j], STALL);
        checkOutput({name, ".fd_pulses"}, fdPulses - baseFd, 1);
        checkOutput({name, ".fd_pulses_relu"}, fdPulsesR - baseFdR, 1);
        w = 0;
        for (int r0 = 0; r0 <= HEIGHT - K; r0++) begin
            for (int c0 = 0; c0 <= WIDTH - K; c0++) begin
                longint s0, s1;
                s0 = windowSum(0, r0, c0);
                s1 = windowSum(1, r0, c0);
                if (baseOut + w < gotM0.size()) begin
                    checkOutput($sformatf("%s.o0[%0d]", name, w), gotM0[baseOut+w], modelResult(s0, 0, 0));
                    checkOutput($sformatf("%s.o1[%0d]", name, w), gotM1[baseOut+w], modelResult(s1, 0, 0));
                    checkOutput($sformatf("%s.fd[%0d]", name, w), gotFd[baseOut+w], (w == NUM_OUT - 1));
                end
                if (baseR + w < gotR0.size()) begin
                    checkOutput($sformatf("%s.r0[%0d]", name, w), gotR0[baseR+w], modelResult(s0, 1, 1));
                    checkOutput($sformatf("%s.r1[%0d]", name, w), gotR1[baseR+w], modelResult(s1, 1, 1));
                    checkOutput($sformatf("%s.fdr[%0d]", name, w), gotFdR[baseR+w], (w == NUM_OUT - 1));
                end
                w++;
            end
        end
    endtask

    initial begin
        int b;
        resetDut();
        @(negedge clk);
        checkOutput("rst.in_ready", in_ready, 1);
        checkOutput("rst.valid_out", valid_out_conv, 0);
        checkOutput("rst.frame_done", frame_done, 0);
        checkOutput("rst.conv_out", conv_out, 0);

        // All ones: each window sums 2*9 = 18.
        setWeights(1);
        loadWeights();
        setPixels(1);
        runFrame("ones", 0, b);
        if (gotM0.size() > b) checkOutput("ones.anchor", gotM0[b], 18);
        if (gotR0.size() > b) checkOutput("ones.anchor_relu", gotR0[b], 9);

        // Ramp on ch0, single centre weight: output is the window centre.
        setWeights(0);
        wt[0][0][1][1] = 1;
        loadWeights();
        for (int r = 0; r < HEIGHT; r++)
            for (int c = 0; c < WIDTH; c++) begin
                pix[0][r][c] = r * WIDTH + c;
                pix[1][r][c] = 0;
            end
        runFrame("ramp", 0, b);
        if (gotM0.size() > b + 15) begin
            checkOutput("ramp.first", gotM0[b], 7);
            checkOutput("ramp.last", gotM0[b+15], 28);
        end

        // Saturation in both directions.
        setWeights(127);
        loadWeights();
        setPixels(2047);
        runFrame("sat_pos", 0, b);
        if (gotM0.size() > b) checkOutput("sat_pos.anchor", gotM0[b], 2047);
        setWeights(-127);
        loadWeights();
        runFrame("sat_neg", 0, b);
        if (gotM0.size() > b) checkOutput("sat_neg.anchor", gotM0[b], -2048);
        if (gotR0.size() > b) checkOutput("sat_neg.anchor_relu", gotR0[b], 0);

        // Randomized frames: small values (no saturation) and full range.
        randomWeights(8);
        loadWeights();
        randomPixels(40);
        runFrame("rand_small", 0, b);
        randomWeights(127);
        loadWeights();
        randomPixels(2047);
        runFrame("rand_full", 0, b);

        // Reset during MAC tap 4 of the first window.
        randomWeights(10);
        loadWeights();
        randomPixels(60);
        b = gotM0.size();
        applyStimulus(0, WIN_PIX);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort.in_ready", in_ready, 1);
        checkOutput("abort.valid_out", valid_out_conv, 0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abort.no_output", gotM0.size() - b, 0);
        randomPixels(60);
        runFrame("after_abort", 0, b);

        // Weight write during MAC is ignored; the same write in IDLE applies.
        setWeights(1);
        loadWeights();
        randomPixels(50);
        runFrame("we_in_mac", 1, b);
        writeWeight(0, 0, 0, 0, 5);
        wt[0][0][0][0] = 5;
        runFrame("we_in_idle", 0, b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_mac_layer.md
# conv_mac_layer

Parametrised multi-channel 2-D convolution layer for the quantized inference pipeline; successor to the fixed 3-channel, 5x5, 12x12 conv stage. Accepts a raster pixel stream of IN_CH channels from the preceding pool stage and produces OUT_CH convolved, scaled and saturated channels for the next pool/FC stage. Weights are runtime-loadable. One time-multiplexed MAC array is used per output position, so the block back-pressures its input while computing.

## Interface
- IN_CH, 3: input channels.
- OUT_CH, 3: output channels.
- WIDTH, 12: input frame width in pixels.
- HEIGHT, 12: input frame height in pixels.
- K, 5: square kernel size; valid convolution, stride 1.
- DATA_BITS, 12: signed input/output sample width.
- W_BITS, 8: signed weight width.
- SHIFT, 1: arithmetic right shift applied to the accumulator before saturation.
- RELU_EN, 0: 1 = clamp negative results to 0.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid_in  in  1  pixel present on data_in.
- in_ready  out  1  block can accept a pixel; a transfer happens when valid_in & in_ready.
- data_in  in  IN_CH*DATA_BITS  channel c at bits [c*DATA_BITS +: DATA_BITS].
- w_we  in  1  weight write strobe.
- w_addr  in  clog2(OUT_CH*IN_CH*K*K)  weight index = ((oc*IN_CH+ic)*K+ky)*K+kx.
- w_data  in  W_BITS  signed weight.
- valid_out_conv  out  1  one-cycle pulse; conv_out is valid.
- conv_out  out  OUT_CH*DATA_BITS  channel o at bits [o*DATA_BITS +: DATA_BITS].
- frame_done  out  1  one-cycle pulse with the last output of a frame.

## Operation
- Per input channel, a line-window buffer holds (K-1)*WIDTH+K samples and shifts only on an accepted pixel. Column and row counters advance on each accepted pixel; column wraps at WIDTH-1 -> 0 and increments row; row wraps at HEIGHT-1 -> 0.
- A window is complete when the accepted pixel has row >= K-1 and col >= K-1. Otherwise the pixel is absorbed and the FSM stays in IDLE.
- FSM states:
  - IDLE: in_ready=1. On an accepted pixel that completes a window, clear tap counter and accumulators and go to MAC.
  - MAC: in_ready=0. Each cycle, tap (ky,kx) = tap counter; for every oc, acc[oc] += sum over ic of window[ic][ky][kx]*w[oc][ic][ky][kx]. After tap K*K-1, go to OUT.
  - OUT: in_ready=0. Register conv_out and pulse valid_out_conv; pulse frame_done if the window was the frame's last (row=HEIGHT-1, col=WIDTH-1). Next state is IDLE.
- Window contents are stable through MAC and OUT because the buffer does not shift while in_ready=0.
- Arithmetic: products are signed DATA_BITS+W_BITS. Accumulator width ACC_BITS = DATA_BITS+W_BITS+clog2(K*K*IN_CH), which cannot overflow.
- Result = acc >>> SHIFT. If RELU_EN, negatives become 0. Then saturate to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1]; never wrap.
- Weight writes are applied only in IDLE. A w_we asserted in MAC or OUT is ignored, and the driver must wait for in_ready=1. Weights are not cleared by reset.
- Outputs per frame: (WIDTH-K+1)*(HEIGHT-K+1).

## Timing
- Reset clears the FSM to IDLE, the counters, the buffers, the accumulators and conv_out to 0, and valid_out_conv and frame_done to 0. in_ready reads 1 in the first cycle after reset is released.
- Reset asserted mid-MAC aborts the computation with no output pulse; the partial frame is discarded.
- A pixel accepted at cycle t that completes a window gives: MAC during t+1..t+K*K; valid_out_conv at t+K*K+1; in_ready=0 during t+1..t+K*K+1; in_ready=1 again at t+K*K+2.
- A non-window pixel gives no stall; back-to-back acceptance is allowed.
- valid_in high while in_ready=0 is held by the source and is not consumed.
- There is no output back-pressure; downstream must take the pulse.

## Structure
- Shared package conv_pkg holds the FSM state enum (IDLE/MAC/OUT), the acc_bits(DATA_BITS,W_BITS,K,IN_CH) function, and a sat_shift function (shift, ReLU, saturate).
- One sub-module, line_window_buf (params WIDTH, K, DATA_BITS), provides shift-on-enable storage and a window tap read port, instantiated IN_CH times.
- The weight register file and MAC array live in the top.

## Test plan
- Params IN_CH=2, OUT_CH=2, W=H=6, K=3, SHIFT=0. All weights 1, all pixels 1 -> 16 outputs per frame, each =18; frame_done coincides with the 16th.
- Same config, ramp input pixel=row*6+col on ch0, ch1=0, only w[0][0][1][1]=1 -> out ch0 equals the centre pixel (7,8,9,10,13,...); ch1=0.
- Saturation: pixels 2047, all weights 127, DATA_BITS=12 -> every output 2047. Negate the weights -> -2048; with RELU_EN=1 -> 0.
- Handshake: valid_in held high continuously -> in_ready low exactly K*K+1=10 cycles after each window-completing pixel; total accepted pixels = 36, no duplicates or drops.
- Reset at MAC tap 4 -> no valid_out_conv, in_ready=1 next cycle, counters 0. A fresh frame then yields correct results.
- w_we during MAC with a new value -> that output and the next outputs use the old weight; the same write issued in IDLE takes effect on the next window.
